// File: rtl/gpu_regfile_pkg.sv
// Shared constants and the write-to-read forwarding helper for the GPU register file.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package gpu_regfile_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 6;

    // Forwarding operates on the widest supported port; callers widen and narrow with casts.
    localparam int FW_AW = 16;
    localparam int FW_DW = 128;

    typedef logic [FW_AW-1:0] fw_addr_t;
    typedef logic [FW_DW-1:0] fw_data_t;

    // Port A beats port B, and either beats the stored word.
    function automatic fw_data_t fwd(
        input fw_addr_t x,
        input logic     wa_en,
        input fw_addr_t wa_addr,
        input fw_data_t wa_data,
        input logic     wb_en,
        input fw_addr_t wb_addr,
        input fw_data_t wb_data,
        input fw_data_t mem_word
    );
        if (wa_en && (wa_addr == x)) begin
            return wa_data;
        end else if (wb_en && (wb_addr == x)) begin
            return wb_data;
        end
        return mem_word;
    endfunction

endpackage

// File: rtl/gpu_regfile_scoreboard.sv
// Pending-load bitmap; raises busy while a read operand still waits for load data.
// Latency: pend_set visible next cycle; a load return clears busy in the same cycle.
// Backpressure: busy is the stall returned to the issue stage.
module gpu_regfile_scoreboard
    import gpu_regfile_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pend_set,
    input  logic [AW-1:0] pend_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic          exe,
    input  logic [AW-1:0] srca,
    input  logic [AW-1:0] dsta,
    output logic          busy
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] pend;

    // A register still counts as pending unless its load lands this very cycle.
    function automatic logic waiting(input logic [AW-1:0] x);
        return pend[x] & ~(wb_en & (wb_addr == x));
    endfunction

    always_comb begin
        busy = ~reset & exe & (waiting(srca) | waiting(dsta));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            if (wb_en) begin
                pend[wb_addr] <= 1'b0;
            end
            // Later assignment wins: a new load to the same register outranks the return.
            if (pend_set) begin
                pend[pend_addr] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_regfile_sb.sv
// Register file with two bypassed read ports, delayed copies and a load scoreboard.
// Latency: address to srcd/dstd one advance; srcdp/dstdp two advances.
// Backpressure: busy blocks exe; all output registers hold while not advancing.
module gpu_regfile_sb
    import gpu_regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          exe,
    input  logic [AW-1:0] srca,
    input  logic [AW-1:0] dsta,
    output logic [DW-1:0] srcd,
    output logic [DW-1:0] srcdp,
    output logic [DW-1:0] dstd,
    output logic [DW-1:0] dstdp,
    input  logic          wa_en,
    input  logic [AW-1:0] wa_addr,
    input  logic [DW-1:0] wa_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          pend_set,
    input  logic [AW-1:0] pend_addr,
    output logic          busy,
    output logic          collide
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] mem [NREG];
    logic          adv;
    logic          same_addr;
    logic          wb_write;
    logic [DW-1:0] src_v;
    logic [DW-1:0] dst_v;

    gpu_regfile_scoreboard #(.AW(AW)) u_sb (
        .clk       (sys_clk),
        .reset     (reset),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .exe       (exe),
        .srca      (srca),
        .dsta      (dsta),
        .busy      (busy)
    );

    always_comb begin
        adv       = exe & ~busy;
        same_addr = wa_addr == wb_addr;
        // On a collision the load data is discarded; port A owns the register.
        wb_write  = wb_en & ~(wa_en & same_addr);
        src_v = DW'(fwd(FW_AW'(srca), wa_en, FW_AW'(wa_addr), FW_DW'(wa_data),
                        wb_en, FW_AW'(wb_addr), FW_DW'(wb_data), FW_DW'(mem[srca])));
        dst_v = DW'(fwd(FW_AW'(dsta), wa_en, FW_AW'(wa_addr), FW_DW'(wa_data),
                        wb_en, FW_AW'(wb_addr), FW_DW'(wb_data), FW_DW'(mem[dsta])));
    end

    // Storage is unreset; only the write strobes are gated by reset.
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            if (wa_en) begin
                mem[wa_addr] <= wa_data;
            end
            if (wb_write) begin
                mem[wb_addr] <= wb_data;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            srcd    <= '0;
            srcdp   <= '0;
            dstd    <= '0;
            dstdp   <= '0;
            collide <= 1'b0;
        end else begin
            collide <= wa_en & wb_en & same_addr;
            if (adv) begin
                srcd  <= src_v;
                srcdp <= srcd;
                dstd  <= dst_v;
                dstdp <= dstd;
            end
        end
    end

endmodule
